serial_gate_sequencer: RTL and testbench
========================================

// Module: serial_gate_sequencer
// PURPOSE
//  Sequences one shared combinational 2-input gate unit (p,q -> s) to reduce an
//  N-bit operand to one bit (OR/AND/XOR/NOR) over WIDTH-1 clock cycles, in place
//  of a cascaded gate tree. Sits between a requester (start/done handshake) and
//  the gate unit: drives gate_p/gate_q/gate_op, samples gate_s in the same cycle.
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range >= 2
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; accepted only when busy=0
//  abort    in   1      cancel in-flight reduction
//  op       in   2      00 OR, 01 AND, 10 XOR, 11 NOR; captured at accept
//  din      in   WIDTH  operand; captured at accept
//  busy     out  1      reduction in progress
//  done     out  1      one-cycle pulse: result valid/updated
//  result   out  1      registered reduction result, held until next done
//  gate_op  out  2      op for shared gate: 00 OR, 01 AND, 10 XOR (NOR runs as OR)
//  gate_p   out  1      gate operand p (accumulator)
//  gate_q   out  1      gate operand q (current operand bit)
//  gate_s   in   1      combinational gate output
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state IDLE; busy, done, result, gate_p,
//   gate_q, gate_op, accumulator, index, operand register all 0.
//  FSM: IDLE, RUN.
//  IDLE: busy=0, gate_p=gate_q=0. On edge with start=1: opnd<=din, op_r<=op,
//   acc<=din[0], idx<=1, state<=RUN. start and abort together in IDLE: start wins.
//  RUN: busy=1; gate_p=acc, gate_q=opnd[idx], gate_op=(op_r==11)?00:op_r.
//   Each edge: acc<=gate_s, idx<=idx+1.
//   Edge with idx==WIDTH-1: result<=(op_r==11)?~gate_s:gate_s, done<=1,
//   state<=IDLE.
//  Latency: start sampled at edge E0; done=1 and busy=0 in the cycle after
//   edge E(WIDTH-1); done is low in every other cycle.
//  abort=1 in RUN: state<=IDLE at next edge; no done pulse; result unchanged.
//   abort has priority over the final-step completion.
//  start while busy=1: ignored, with no effect on the in-flight operation.
//  Back-to-back: start=1 in the done cycle is accepted (state is IDLE).
//  Index width: clog2(WIDTH); idx never exceeds WIDTH-1; no wrap.
//  din/op changes after accept have no effect on the current reduction.
//  rst_n asserted mid-RUN: immediate return to reset values; no done pulse.
// TESTING  (WIDTH=8; bench models gate unit combinationally per gate_op)
//  OR din=8'h00 -> done 7 cycles after start edge, result=0;
//   din=8'h10 -> result=1.
//  AND din=8'hFF -> result=1; din=8'hFE -> result=0; gate_op=01 throughout RUN.
//  XOR din=8'hA5 -> 0; din=8'h07 -> 1.
//   NOR din=8'h00 -> 1 with gate_op=00 during RUN.
//  Start OR 8'h01 (result=1), abort at 3rd RUN cycle -> busy=0 next cycle,
//   no done, result stays 1; start during RUN ignored.
//  Start accepted in done cycle -> second done exactly 7 cycles later,
//   with correct result.
//  rst_n=0 mid-RUN (between edges) -> busy/done/result/gate_* = 0 immediately;
//   after release, new start completes normally.

Source files
------------

// File: rtl/serial_gate_sequencer_if.sv
// -----------------------------------------------------------------------------
// serial_gate_sequencer_if
//   Requester-side handshake bundle for serial_gate_sequencer.
//   master : the requester (drives start/abort/op/din, observes busy/done/result)
//   slave  : the sequencer (observes the request, drives busy/done/result)
// Signals
//   start   request; accepted by the sequencer only while busy=0
//   abort   cancel an in-flight reduction
//   op      reduction op: 00 OR, 01 AND, 10 XOR, 11 NOR
//   din     operand, WIDTH bits
//   busy    reduction in progress
//   done    one-cycle pulse, result valid/updated
//   result  registered reduction result
// -----------------------------------------------------------------------------
interface serial_gate_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             result;

  modport master (
    output start, abort, op, din,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, op, din,
    output busy, done, result
  );
endinterface

// File: rtl/serial_gate_sequencer.sv
// -----------------------------------------------------------------------------
// serial_gate_sequencer
//   Reduces a WIDTH-bit operand to a single bit (OR/AND/XOR/NOR) by stepping one
//   shared external 2-input gate unit over WIDTH-1 cycles instead of building a
//   gate tree. Each RUN cycle presents (accumulator, next operand bit) to the
//   gate and folds the gate output back into the accumulator on the clock edge.
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      requester handshake (start/abort/op/din -> busy/done/result)
//   gate_op  out  op for the shared gate: 00 OR, 01 AND, 10 XOR
//   gate_p   out  gate operand p (accumulator)
//   gate_q   out  gate operand q (current operand bit)
//   gate_s   in   combinational gate output, sampled in the same cycle
// The WIDTH parameter must match the WIDTH of the connected interface.
// -----------------------------------------------------------------------------
module serial_gate_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_gate_sequencer_if.slave    req,
  output logic [1:0]                gate_op,
  output logic                      gate_p,
  output logic                      gate_q,
  input  logic                      gate_s
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] opnd_reg,   opnd_next;
  logic [1:0]       op_reg,     op_next;
  logic             acc_reg,    acc_next;
  logic [IDX_W-1:0] idx_reg,    idx_next;
  logic             done_reg,   done_next;
  logic             result_reg, result_next;
  logic             busy;

  // Operand bit selected by idx_reg. Built as a one-hot AND-OR so that an
  // index value outside 0..WIDTH-1 (non-power-of-two WIDTH) simply yields 0
  // instead of an out-of-range part select.
  logic [WIDTH-1:0] bit_sel;
  logic             cur_bit;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (idx_reg == IDX_W'(gi)) & opnd_reg[gi];
  end

  assign cur_bit = |bit_sel;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      opnd_reg   <= '0;
      op_reg     <= '0;
      acc_reg    <= 1'b0;
      idx_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opnd_reg   <= opnd_next;
      op_reg     <= op_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      done_reg   <= done_next;
      result_reg <= result_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    opnd_next   = opnd_reg;
    op_next     = op_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    done_next   = 1'b0;
    result_next = result_reg;
    busy        = 1'b0;
    gate_op     = 2'b00;
    gate_p      = 1'b0;
    gate_q      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // abort is meaningless here, so a simultaneous start always wins.
        if (req.start) begin
          opnd_next  = req.din;
          op_next    = req.op;
          acc_next   = req.din[0];
          idx_next   = IDX_W'(1);
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        busy    = 1'b1;
        gate_p  = acc_reg;
        gate_q  = cur_bit;
        // NOR is reduced as OR and inverted once at the end.
        gate_op = (op_reg == OP_NOR) ? 2'b00 : op_reg;

        if (req.abort) begin
          // Abort beats the final step: no done, result untouched.
          state_next = ST_IDLE;
        end else begin
          acc_next = gate_s;
          if (idx_reg == LAST_IDX) begin
            result_next = (op_reg == OP_NOR) ? ~gate_s : gate_s;
            done_next   = 1'b1;
            state_next  = ST_IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign req.busy   = busy;
  assign req.done   = done_reg;
  assign req.result = result_reg;

endmodule

// File: tb/tb_serial_gate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_gate_sequencer
//   Self-checking bench for serial_gate_sequencer (WIDTH=8). The shared gate
//   unit is modelled combinationally. Expected results come from a table of
//   known vectors and from a whole-word reference reduction for random traffic.
// -----------------------------------------------------------------------------
module tb_serial_gate_sequencer;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gate_op;
  logic       gate_p;
  logic       gate_q;
  logic       gate_s;

  always #5 clk = ~clk;

  serial_gate_sequencer_if #(.WIDTH(WIDTH)) rif ();

  serial_gate_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rif),
    .gate_op (gate_op),
    .gate_p  (gate_p),
    .gate_q  (gate_q),
    .gate_s  (gate_s)
  );

  // Shared gate unit.
  always_comb begin
    case (gate_op)
      2'b00:   gate_s = gate_p | gate_q;
      2'b01:   gate_s = gate_p & gate_q;
      2'b10:   gate_s = gate_p ^ gate_q;
      default: gate_s = 1'b0;
    endcase
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  logic last_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Whole-word reduction of the operand.
  function automatic logic ref_reduce(input logic [1:0] op, input logic [WIDTH-1:0] d);
    case (op)
      2'b00:   return (d != '0);
      2'b01:   return (d == {WIDTH{1'b1}});
      2'b10:   return ($countones(d) % 2) == 1;
      default: return (d == '0);
    endcase
  endfunction

  // Partial reduction of bits [k-1:0]; NOR accumulates as OR.
  function automatic logic ref_prefix(input logic [1:0] op, input logic [WIDTH-1:0] d, input int k);
    logic [WIDTH-1:0] mask;
    mask = WIDTH'((1 << k) - 1);
    case (op)
      2'b01:   return ((d | ~mask) == {WIDTH{1'b1}});
      2'b10:   return ($countones(d & mask) % 2) == 1;
      default: return ((d & mask) != '0);
    endcase
  endfunction

  // Full reduction starting at a negedge with the DUT idle; returns at the
  // negedge of the done cycle, so a following call is a back-to-back start.
  // poke_k in 1..WIDTH-1 raises start (with junk op/din) during that RUN cycle.
  task automatic run_txn(input string tag, input logic [1:0] op_i, input logic [WIDTH-1:0] din_i,
                         input logic exp_i, input int poke_k, input bit abort_at_start);
    bit   seq_ok;
    bit   gate_ok;
    logic [1:0] exp_gop;
    seq_ok  = 1'b1;
    gate_ok = 1'b1;
    exp_gop = (op_i == 2'b11) ? 2'b00 : op_i;
    rif.start = 1'b1;
    rif.op    = op_i;
    rif.din   = din_i;
    rif.abort = abort_at_start;
    @(posedge clk);
    @(negedge clk);
    rif.start = 1'b0;
    rif.abort = 1'b0;
    rif.op    = 2'($urandom);
    rif.din   = WIDTH'($urandom);
    for (int k = 1; k < WIDTH; k++) begin
      if (!(rif.busy === 1'b1 && rif.done === 1'b0)) seq_ok = 1'b0;
      if (gate_op !== exp_gop || gate_q !== din_i[k] || gate_p !== ref_prefix(op_i, din_i, k))
        gate_ok = 1'b0;
      rif.start = (k == poke_k);
      rif.op    = 2'($urandom);
      rif.din   = WIDTH'($urandom);
      @(negedge clk);
    end
    rif.start = 1'b0;
    check({tag, ".run_seq"}, 32'(seq_ok), 32'd1);
    check({tag, ".gate"},    32'(gate_ok), 32'd1);
    check({tag, ".done"},    32'(rif.done), 32'd1);
    check({tag, ".busy"},    32'(rif.busy), 32'd0);
    check({tag, ".result"},  32'(rif.result), 32'(exp_i));
    last_result = exp_i;
    $display("txn %s op=%0d din=%02h result=%0b exp=%0b", tag, op_i, din_i, rif.result, exp_i);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check({tag, ".done_low"}, 32'(rif.done), 32'd0);
    check({tag, ".idle"},     32'(rif.busy), 32'd0);
  endtask

  // Start, then assert abort (with a competing start) in RUN cycle abort_k.
  task automatic abort_seq(input string tag, input logic [1:0] op_i, input logic [WIDTH-1:0] din_i,
                           input int abort_k);
    bit seen_done;
    seen_done = 1'b0;
    rif.start = 1'b1;
    rif.op    = op_i;
    rif.din   = din_i;
    @(posedge clk);
    @(negedge clk);
    rif.start = 1'b0;
    for (int k = 1; k < abort_k; k++) @(negedge clk);
    check({tag, ".busy_before"}, 32'(rif.busy), 32'd1);
    rif.abort = 1'b1;
    rif.start = 1'b1;
    rif.op    = 2'b00;
    rif.din   = {WIDTH{1'b1}};
    @(negedge clk);
    rif.abort = 1'b0;
    rif.start = 1'b0;
    check({tag, ".busy_after"}, 32'(rif.busy), 32'd0);
    for (int k = 0; k < WIDTH; k++) begin
      if (rif.done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    check({tag, ".no_done"}, 32'(seen_done), 32'd0);
    check({tag, ".result"},  32'(rif.result), 32'(last_result));
    $display("txn %s op=%0d din=%02h abort_k=%0d result=%0b exp=%0b",
             tag, op_i, din_i, abort_k, rif.result, last_result);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic             exp;
    bit               abort_at_start;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 8'h10, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{2'b01, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 8'hA5, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 8'h07, 1'b1, 1'b0};
    vecs[6] = '{2'b11, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{2'b11, 8'h40, 1'b0, 1'b0};
    vecs[8] = '{2'b00, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{2'b10, 8'hA5, 1'b0, 1'b0};

    rst_n     = 1'b0;
    rif.start = 1'b0;
    rif.abort = 1'b0;
    rif.op    = 2'b11;
    rif.din   = '1;
    last_result = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst.busy",    32'(rif.busy),   32'd0);
    check("rst.done",    32'(rif.done),   32'd0);
    check("rst.result",  32'(rif.result), 32'd0);
    check("rst.gate_op", 32'(gate_op),    32'd0);
    check("rst.gate_p",  32'(gate_p),     32'd0);
    check("rst.gate_q",  32'(gate_q),     32'd0);
    rst_n = 1'b1;
    idle_cycle("rst");

    // Known vectors, each followed by an idle cycle.
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].exp, 0, vecs[i].abort_at_start);
      idle_cycle($sformatf("vec%0d", i));
    end

    // Abort at 3rd RUN cycle with a start pending: previous result 0 must hold.
    abort_seq("abort3", 2'b00, 8'h01, 3);
    // Result 1 held across an abort that lands on the final step.
    run_txn("pre_abort7", 2'b00, 8'h01, 1'b1, 4, 1'b0);
    idle_cycle("pre_abort7");
    abort_seq("abort7", 2'b01, 8'hFE, WIDTH - 1);

    // Back-to-back: second start issued in the done cycle.
    run_txn("b2b_a", 2'b10, 8'h07, 1'b1, 0, 1'b0);
    run_txn("b2b_b", 2'b11, 8'h00, 1'b1, 0, 1'b0);
    run_txn("b2b_c", 2'b01, 8'hFE, 1'b0, 2, 1'b0);
    idle_cycle("b2b");

    // Asynchronous reset in the middle of a reduction.
    run_txn("pre_rst", 2'b01, 8'hFF, 1'b1, 0, 1'b0);
    idle_cycle("pre_rst");
    rif.start = 1'b1;
    rif.op    = 2'b01;
    rif.din   = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst.busy_before", 32'(rif.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.busy",    32'(rif.busy),   32'd0);
    check("midrst.done",    32'(rif.done),   32'd0);
    check("midrst.result",  32'(rif.result), 32'd0);
    check("midrst.gate_op", 32'(gate_op),    32'd0);
    check("midrst.gate_p",  32'(gate_p),     32'd0);
    check("midrst.gate_q",  32'(gate_q),     32'd0);
    $display("txn midrst result=%0b exp=0", rif.result);
    @(negedge clk);
    rst_n = 1'b1;
    last_result = 1'b0;
    idle_cycle("post_rst");
    run_txn("post_rst", 2'b10, 8'h07, 1'b1, 0, 1'b0);
    idle_cycle("post_rst");

    // Random traffic against the whole-word reference.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]       r_op;
      logic [WIDTH-1:0] r_din;
      int               r_poke;
      r_op   = 2'($urandom_range(0, 3));
      r_din  = WIDTH'($urandom);
      r_poke = $urandom_range(0, WIDTH);
      run_txn($sformatf("rnd%0d", i), r_op, r_din, ref_reduce(r_op, r_din), r_poke, 1'b0);
      if ($urandom_range(0, 1) == 0) idle_cycle($sformatf("rnd%0d", i));
    end
    idle_cycle("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
